data_cache_ctrl: RTL and testbench
==================================

# data_cache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller for the memory stage. It holds the tag, valid and data arrays, and performs the lookup. It produces `hit` and `cache_rdata`, which drive the downstream hit/miss data select (`hit` → select, `cache_rdata` → cache input, `mem_rdata` → memory input). It also runs the miss and write-through handshake with main memory and stalls the pipeline until each access completes.

## Interface
Parameters:
- `WD`, 32, data word width
- `AW`, 32, byte address width
- `SETS`, 64, number of lines, one word each; power of two, ≥ 2

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  1  load/store request present
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  AW  byte address; bits [1:0] ignored
- `req_wdata`  in  WD  store data
- `hit`  out  1  load hit this cycle; data select for the downstream mux
- `cache_rdata`  out  WD  data word of the indexed line
- `stall`  out  1  hold the pipeline; request must stay stable while high
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  memory write
- `mem_addr`  out  AW  word-aligned address, bits [1:0] = 0
- `mem_wdata`  out  WD  memory write data
- `mem_ack`  in  1  memory access complete; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  WD  memory read data; also feeds the downstream mux directly

## Operation
Address fields:
- `IDX = log2(SETS)`
- index = `req_addr[IDX+1:2]`
- tag = `req_addr[AW-1:IDX+2]`
- match = `valid[index] && tag_arr[index] == tag`

`cache_rdata` is always `data_arr[index]`, combinational, in every state.

FSM states: IDLE, RD_MISS, WR_THRU.

IDLE:
- `mem_req` = 0.
- Load (`req_valid & !req_we`) with match:
  - `hit` = 1, `stall` = 0; stay in IDLE.
- Load with no match:
  - `hit` = 0, `stall` = 1; next state RD_MISS.
- Store (`req_valid & req_we`):
  - `hit` = 0, `stall` = 1; next state WR_THRU.
- No request: `hit` = 0, `stall` = 0.

RD_MISS:
- Drives `mem_req` = 1, `mem_we` = 0, `mem_addr` = `{req_addr[AW-1:2], 2'b00}`.
- While `mem_ack` = 0: `stall` = 1.
- Cycle with `mem_ack` = 1:
  - `stall` = 0 and `hit` = 0, so the downstream mux passes `mem_rdata` and the load retires.
  - On the edge: `data_arr[index]` ← `mem_rdata`, `tag_arr[index]` ← tag, `valid[index]` ← 1; next state IDLE.

WR_THRU:
- Drives `mem_req` = 1, `mem_we` = 1, `mem_addr` as above, `mem_wdata` = `req_wdata`.
- While `mem_ack` = 0: `stall` = 1.
- Cycle with `mem_ack` = 1: `stall` = 0.
  - On the edge: if match, `data_arr[index]` ← `req_wdata`. On a miss, no allocation.
  - Next state IDLE.

`hit` is 0 in every state except IDLE.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE, all `valid` = 0.
  - `hit`, `stall`, `mem_req`, `mem_we` = 0 immediately.
  - `mem_addr`, `mem_wdata` = 0.
  - Tag and data arrays are not cleared.
- Reset during RD_MISS or WR_THRU aborts the access: `mem_req` drops the same cycle and the line is not updated.
- Load hit: 0 extra cycles; retires in the request cycle.
- Load miss or store: 1 cycle in IDLE, then N ≥ 1 cycles in RD_MISS/WR_THRU. Retires in the `mem_ack` cycle. Minimum total is 2 cycles.
- `mem_req` is a Moore output (state only); all address and data outputs are held stable until `mem_ack`.
- `mem_ack` seen while in IDLE is ignored.
- A new request may be presented in the cycle after retirement. Back-to-back loads to a just-refilled line hit.
- Any two addresses with equal index evict each other (no associativity).

## Structure
- Package `cache_pkg`:
  - state enum `cache_state_t` {IDLE, RD_MISS, WR_THRU}
  - default `WD`/`AW`/`SETS`
  - helper functions for index/tag extraction
- Sub-module `cache_array`: flop-based valid, tag and data arrays. One combinational read port and one write port (index, tag, data, set_valid). `valid` is reset asynchronously.
- Top level (`data_cache_ctrl`): FSM plus output decode only.

## Test plan
- Reset, then load `0x100`: miss, `mem_req` appears in cycle 1; `mem_ack` with `mem_rdata` = `0xDEADBEEF` → `stall` = 0, `hit` = 0. Repeat load of `0x100` → `hit` = 1, `cache_rdata` = `0xDEADBEEF`, 0 stall.
- Store `0x100` ← `0x12345678` after a refill of that line: WR_THRU with `mem_we` = 1 and `mem_wdata` = `0x12345678`. Subsequent load of `0x100` hits with `0x12345678`.
- Store to an uncached `0x200`: write-through occurs, no allocation. Load of `0x200` then misses.
- Conflict (`SETS` = 64): refill `0x000`, then load `0x100` (same index, different tag) → miss and eviction. Reload of `0x000` misses.
- Memory wait of 5 cycles: `stall` is high for exactly 6 cycles with `mem_addr` stable; a spurious `mem_ack` in IDLE has no effect.
- Assert `rst` mid-RD_MISS: `mem_req` and `stall` drop at once; reload of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, default sizes and address-field helpers for the data cache controller.
package cache_pkg;

    localparam int unsigned DEF_WD   = 32;
    localparam int unsigned DEF_AW   = 32;
    localparam int unsigned DEF_SETS = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } cache_state_t;

    // Line index: word address bits just above the byte offset.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int unsigned iw);
        return (addr >> 2) & ((64'd1 << iw) - 64'd1);
    endfunction

    // Tag: everything above the index field.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned iw);
        return addr >> (iw + 2);
    endfunction

endpackage

// File: rtl/cache_array.sv
// Flop-based valid/tag/data storage with one combinational read port and one write port.
module cache_array #(
    parameter int unsigned WD   = 32,
    parameter int unsigned TW   = 24,
    parameter int unsigned SETS = 64,
    parameter int unsigned IW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [WD-1:0] rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic [WD-1:0] wr_data,
    input  logic          wr_set_valid
);

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tag_arr  [SETS];
    logic [WD-1:0]   data_arr [SETS];

    // Only the valid bits are reset; stale tags and data are masked by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en && wr_set_valid) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr[wr_idx]  <= wr_tag;
            data_arr[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// lookup, hit/stall decode and the refill / write-through handshake with memory.
module data_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned WD   = DEF_WD,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned SETS = DEF_SETS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [WD-1:0] req_wdata,
    output logic          hit,
    output logic [WD-1:0] cache_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [WD-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [WD-1:0] mem_rdata
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = AW - IW - 2;

    cache_state_t  state;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic [AW-1:0] word_addr;
    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic          match;
    logic          wr_en;
    logic [WD-1:0] wr_data;

    assign index     = IW'(addr_index(64'(req_addr), IW));
    assign tag       = TW'(addr_tag(64'(req_addr), IW));
    assign word_addr = {req_addr[AW-1:2], 2'b00};
    assign match     = line_valid && (line_tag == tag);

    // Refill always writes; a write-through only updates a line it already owns.
    assign wr_en   = mem_ack && ((state == RD_MISS) || ((state == WR_THRU) && match));
    assign wr_data = (state == RD_MISS) ? mem_rdata : req_wdata;

    cache_array #(
        .WD   (WD),
        .TW   (TW),
        .SETS (SETS),
        .IW   (IW)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (index),
        .rd_valid     (line_valid),
        .rd_tag       (line_tag),
        .rd_data      (cache_rdata),
        .wr_en        (wr_en),
        .wr_idx       (index),
        .wr_tag       (tag),
        .wr_data      (wr_data),
        .wr_set_valid (1'b1)
    );

    // State plus the memory address/data, captured once when the access leaves IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_we) begin
                            state     <= WR_THRU;
                            mem_addr  <= word_addr;
                            mem_wdata <= req_wdata;
                        end else if (!match) begin
                            state    <= RD_MISS;
                            mem_addr <= word_addr;
                        end
                    end
                end
                RD_MISS, WR_THRU: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore memory strobes; reset forces IDLE asynchronously so they drop at once.
    assign mem_req = (state != IDLE);
    assign mem_we  = (state == WR_THRU);

    // Pipeline-facing decode, forced low while reset is held.
    always_comb begin
        hit   = 1'b0;
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_we && match) begin
                            hit = 1'b1;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                RD_MISS, WR_THRU: stall = !mem_ack;
                default: stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: reference cache model plus a scoreboard of expected retirements.
module tb_data_cache_ctrl;

    typedef struct {
        logic        hit;
        logic [31:0] data;
        int          stalls;
        bit          we;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        hit;
    logic [31:0] cache_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int compared;
    int mismatched;

    exp_t        sb [$];
    bit          ref_valid [64];
    logic [23:0] ref_tag   [64];
    logic [31:0] ref_data  [64];

    data_cache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .hit         (hit),
        .cache_rdata (cache_rdata),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One load or store: predicts from the model, drives the request, acts as memory, checks retirement.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input logic [31:0] mrd);
        exp_t        e;
        exp_t        got;
        int          idx;
        logic [23:0] tg;
        bit          m;
        int          stalls;
        bit          done;
        logic [31:0] waddr;
        logic [31:0] seen;
        idx   = int'(addr[7:2]);
        tg    = addr[31:8];
        m     = ref_valid[idx] && (ref_tag[idx] == tg);
        waddr = {addr[31:2], 2'b00};
        e.we     = we;
        e.hit    = !we && m;
        e.data   = we ? 32'h0 : (m ? ref_data[idx] : mrd);
        e.stalls = (!we && m) ? 0 : lat + 1;
        sb.push_back(e);
        if (!we && !m) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_data[idx]  = mrd;
        end
        if (we && m) ref_data[idx] = wd;

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        mem_ack   = 1'b0;
        stalls    = 0;
        done      = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c >= 1) begin
                mem_ack   = (c == lat + 1);
                mem_rdata = mem_ack ? mrd : $urandom();
            end
            @(negedge clk);
            if (c == 0) begin
                compared++;
                if (mem_req !== 1'b0) begin
                    mismatched++;
                    $display("FAIL idle_mem_req addr=%h got=%b want=0", addr, mem_req);
                end
            end else begin
                compared++;
                if (mem_req !== 1'b1 || mem_we !== we) begin
                    mismatched++;
                    $display("FAIL mem_strobe addr=%h cyc=%0d got req=%b we=%b want req=1 we=%b",
                             addr, c, mem_req, mem_we, we);
                end
                compared++;
                if (mem_addr !== waddr) begin
                    mismatched++;
                    $display("FAIL mem_addr cyc=%0d got=%h want=%h", c, mem_addr, waddr);
                end
                if (we) begin
                    compared++;
                    if (mem_wdata !== wd) begin
                        mismatched++;
                        $display("FAIL mem_wdata cyc=%0d got=%h want=%h", c, mem_wdata, wd);
                    end
                end
            end
            if (stall === 1'b1) begin
                stalls++;
            end else begin
                done = 1'b1;
                got  = sb.pop_front();
                compared++;
                if (hit !== got.hit) begin
                    mismatched++;
                    $display("FAIL retire_hit addr=%h got=%b want=%b", addr, hit, got.hit);
                end
                compared++;
                if (stalls != got.stalls) begin
                    mismatched++;
                    $display("FAIL stall_cycles addr=%h got=%0d want=%0d", addr, stalls, got.stalls);
                end
                if (!got.we) begin
                    seen = hit ? cache_rdata : mem_rdata;
                    compared++;
                    if (seen !== got.data) begin
                        mismatched++;
                        $display("FAIL load_data addr=%h got=%h want=%h", addr, seen, got.data);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL timeout addr=%h no retirement within 200 cycles", addr);
            void'(sb.pop_front());
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if ({hit, stall, mem_req, mem_we} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_strobes got hit/stall/req/we=%b want=0000", {hit, stall, mem_req, mem_we});
        end
        compared++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_miss_hit();
        access(1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        access(1'b0, 32'h100, 32'h0, 0, 32'h0BAD0BAD);
    endtask

    task automatic test_store_hit();
        access(1'b1, 32'h100, 32'h12345678, 0, 32'h0);
        access(1'b0, 32'h100, 32'h0, 0, 32'h0BAD0BAD);
    endtask

    task automatic test_store_uncached();
        access(1'b1, 32'h200, 32'h55AA55AA, 2, 32'h0);
        access(1'b0, 32'h200, 32'h0, 1, 32'hA5A5A5A5);
        access(1'b0, 32'h200, 32'h0, 0, 32'h0);
    endtask

    task automatic test_conflict();
        access(1'b0, 32'h000, 32'h0, 0, 32'h00000AAA);
        access(1'b0, 32'h000, 32'h0, 0, 32'h0);
        access(1'b0, 32'h100, 32'h0, 1, 32'h00000BBB);
        access(1'b0, 32'h000, 32'h0, 0, 32'h00000CCC);
    endtask

    task automatic test_wait_and_spurious_ack();
        access(1'b0, 32'h44, 32'h0, 5, 32'hCAFEF00D);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({hit, stall, mem_req} !== 3'b000) begin
                mismatched++;
                $display("FAIL idle_ack got hit/stall/req=%b want=000", {hit, stall, mem_req});
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        access(1'b0, 32'h44, 32'h0, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            a = ({$urandom_range(0, 2)} << 8) | ({$urandom_range(0, 3)} << 2) | {$urandom_range(0, 3)};
            access(1'(($urandom_range(0, 2)) == 0), a, $urandom(), $urandom_range(0, 3), $urandom());
        end
    endtask

    task automatic test_reset_mid_miss();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h3C4;
        mem_ack   = 1'b0;
        @(negedge clk);
        compared++;
        if (stall !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_setup_stall got=%b want=1", stall);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        compared++;
        if (mem_req !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_setup_req got=%b want=1", mem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if ({mem_req, stall, hit, mem_we} !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_drop got req/stall/hit/we=%b want=0000", {mem_req, stall, hit, mem_we});
        end
        compared++;
        if (mem_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL abort_addr got=%h want=0", mem_addr);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b0, 32'h3C4, 32'h0, 2, 32'h77778888);
        access(1'b0, 32'h3C4, 32'h0, 0, 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_load_miss_hit();
        test_store_hit();
        test_store_uncached();
        test_conflict();
        test_wait_and_spurious_ack();
        test_back_to_back();
        test_reset_mid_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
